// File: rtl/dpram_port_arbiter.sv
// dpram_port_arbiter: shares one DualPortRam port between video, CPU and blitter.
// One RAM transaction at a time: grant, optional wait states, read capture, ack.
module dpram_port_arbiter #(
   parameter int unsigned WAIT_CYCLES = 0,
   parameter bit          HIPRI0      = 1'b1
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [2:0]  req,
   input  logic [2:0]  we,
   input  logic [35:0] addr_in,
   input  logic [23:0] wdata_in,
   output logic [2:0]  gnt,
   output logic [2:0]  ack,
   output logic [7:0]  rdata,
   output logic        busy,
   output logic [11:0] ram_addr,
   output logic [7:0]  ram_wdata,
   output logic        ram_wena,
   input  logic [7:0]  ram_rdata
);

   typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

   state_t      state_q, state_d;
   logic [1:0]  rr_q, rr_d;
   logic [2:0]  cnt_q, cnt_d;
   logic        we_q, we_d;
   logic        wena_q, wena_d;
   logic [11:0] addr_q, addr_d;
   logic [7:0]  wdata_q, wdata_d;
   logic [7:0]  rdata_q, rdata_d;

   logic [1:0]  win;
   logic [11:0] win_addr;
   logic [7:0]  win_wdata;
   logic [2:0]  rr_oh;

   // Round-robin search starts just after the last winner.
   always_comb begin
      win = rr_q;
      unique case (rr_q)
         2'd0:    win = req[1] ? 2'd1 : (req[2] ? 2'd2 : 2'd0);
         2'd1:    win = req[2] ? 2'd2 : (req[0] ? 2'd0 : 2'd1);
         default: win = req[0] ? 2'd0 : (req[1] ? 2'd1 : 2'd2);
      endcase
      if (HIPRI0 && req[0]) win = 2'd0;
   end

   always_comb begin
      win_addr  = addr_in[11:0];
      win_wdata = wdata_in[7:0];
      unique case (win)
         2'd1: begin
            win_addr  = addr_in[23:12];
            win_wdata = wdata_in[15:8];
         end
         2'd2: begin
            win_addr  = addr_in[35:24];
            win_wdata = wdata_in[23:16];
         end
         default: begin
            win_addr  = addr_in[11:0];
            win_wdata = wdata_in[7:0];
         end
      endcase
   end

   always_comb begin
      state_d = state_q;
      rr_d    = rr_q;
      cnt_d   = cnt_q;
      we_d    = we_q;
      wena_d  = 1'b0;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      unique case (state_q)
         IDLE: begin
            if (|req) begin
               state_d = ACCESS;
               rr_d    = win;
               cnt_d   = 3'(WAIT_CYCLES);
               we_d    = we[win];
               wena_d  = we[win];
               addr_d  = win_addr;
               wdata_d = win_wdata;
            end
         end
         ACCESS: begin
            if (cnt_q == 3'd0) begin
               state_d = DONE;
               if (!we_q) rdata_d = ram_rdata;
            end else begin
               cnt_d = cnt_q - 3'd1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         rr_q    <= 2'd2;
         cnt_q   <= '0;
         we_q    <= 1'b0;
         wena_q  <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         rr_q    <= rr_d;
         cnt_q   <= cnt_d;
         we_q    <= we_d;
         wena_q  <= wena_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
      end
   end

   assign rr_oh     = 3'b001 << rr_q;
   assign gnt       = (state_q == ACCESS) ? rr_oh : 3'b000;
   assign ack       = (state_q == DONE) ? rr_oh : 3'b000;
   assign busy      = (state_q != IDLE);
   assign rdata     = rdata_q;
   assign ram_addr  = addr_q;
   assign ram_wdata = wdata_q;
   assign ram_wena  = wena_q;

endmodule

// File: tb/tb_dpram_port_arbiter.sv
// Scoreboard bench for dpram_port_arbiter in two configurations:
// instance 0 WAIT_CYCLES=0 HIPRI0=0, instance 1 WAIT_CYCLES=3 HIPRI0=1.
module tb_dpram_port_arbiter;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h, want 0x%0h at %0t",
                  nm, act, exp, $time);
      end
   endtask

   function automatic bit pct(input int p);
      return $urandom_range(0, 99) < p;
   endfunction

   // Reference arbitration rule: priority override, then rotating search.
   function automatic logic [1:0] pick(input logic [2:0] r,
                                       input logic [1:0] last,
                                       input bit hp);
      if (hp && r[0]) return 2'd0;
      for (int k = 1; k <= 3; k++) begin
         int c;
         c = (int'(last) + k) % 3;
         if (r[c]) return 2'(c);
      end
      return last;
   endfunction

   typedef struct {
      int unsigned n;
      logic [1:0]  who;
      logic        wr;
      logic [11:0] a;
      logic [7:0]  d;
      logic [7:0]  rd;
   } txn_t;

   for (genvar g = 0; g < 2; g++) begin : gi
      localparam int unsigned W = (g == 0) ? 0 : 3;
      localparam bit          H = (g == 1);

      logic        rst_n;
      logic [2:0]  req, we, gnt, ack;
      logic [35:0] addr_in;
      logic [23:0] wdata_in;
      logic [7:0]  rdata, ram_wdata, ram_rdata;
      logic        busy, ram_wena;
      logic [11:0] ram_addr;
      logic [7:0]  ram   [4096];
      logic [7:0]  mem_m [4096];
      txn_t        q[$];
      int unsigned ecnt = 0;
      bit          done = 1'b0;
      logic [2:0]  granted;

      dpram_port_arbiter #(.WAIT_CYCLES(W), .HIPRI0(H)) dut (
         .clk      (clk),
         .reset_n  (rst_n),
         .req      (req),
         .we       (we),
         .addr_in  (addr_in),
         .wdata_in (wdata_in),
         .gnt      (gnt),
         .ack      (ack),
         .rdata    (rdata),
         .busy     (busy),
         .ram_addr (ram_addr),
         .ram_wdata(ram_wdata),
         .ram_wena (ram_wena),
         .ram_rdata(ram_rdata)
      );

      always @(posedge clk) if (ram_wena) ram[ram_addr] <= ram_wdata;
      assign ram_rdata = ram[ram_addr];

      // Transaction-level model: one access per 3+W edges, pushed at grant.
      initial begin : model
         int unsigned next_arb;
         logic [1:0]  last;
         txn_t        t;
         next_arb = 0;
         last     = 2'd2;
         forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
               q.delete();
               next_arb = 0;
               last     = 2'd2;
            end else begin
               ecnt++;
               if (ecnt >= next_arb && req != 3'b000) begin
                  t.n   = ecnt;
                  t.who = pick(req, last, H);
                  last  = t.who;
                  t.wr  = we[t.who];
                  t.a   = 12'(addr_in >> (12 * int'(t.who)));
                  t.d   = 8'(wdata_in >> (8 * int'(t.who)));
                  if (t.wr) mem_m[t.a] = t.d;
                  t.rd  = mem_m[t.a];
                  q.push_back(t);
                  next_arb = ecnt + W + 3;
               end
            end
         end
      end

      initial begin : mon
         logic [7:0] exp_rd;
         logic [2:0] eg, ea;
         logic       eb, ew;
         txn_t       t;
         exp_rd = 8'h00;
         forever begin
            @(negedge clk);
            if (!rst_n) begin
               exp_rd = 8'h00;
            end else begin
               eg = 3'b000;
               ea = 3'b000;
               eb = 1'b0;
               ew = 1'b0;
               if (q.size() != 0) begin
                  t = q[0];
                  if (ecnt <= t.n + W) begin
                     eg = 3'b001 << t.who;
                     eb = 1'b1;
                     ew = t.wr && (ecnt == t.n);
                     chk($sformatf("g%0d ram_addr", g), 32'(ram_addr), 32'(t.a));
                     chk($sformatf("g%0d ram_wdata", g), 32'(ram_wdata), 32'(t.d));
                  end else if (ecnt == t.n + W + 1) begin
                     ea = 3'b001 << t.who;
                     eb = 1'b1;
                     if (!t.wr) exp_rd = t.rd;
                     void'(q.pop_front());
                  end
               end
               chk($sformatf("g%0d gnt", g), 32'(gnt), 32'(eg));
               chk($sformatf("g%0d ack", g), 32'(ack), 32'(ea));
               chk($sformatf("g%0d busy", g), 32'(busy), 32'(eb));
               chk($sformatf("g%0d ram_wena", g), 32'(ram_wena), 32'(ew));
               chk($sformatf("g%0d rdata", g), 32'(rdata), 32'(exp_rd));
            end
         end
      end

      task automatic rnd_fields(input int i);
         logic [11:0] a;
         a = ($urandom_range(0, 7) == 0) ? 12'hFFF : 12'($urandom_range(0, 15));
         we[i] = 1'($urandom_range(0, 1));
         addr_in[12*i +: 12] = a;
         wdata_in[8*i +: 8]  = 8'($urandom);
      endtask

      // Requester behaviour: hold until ack, scramble inputs after grant.
      task automatic step(input int pr, input int pk, input int pw,
                          input int pd, input logic [2:0] m);
         for (int i = 0; i < 3; i++) begin
            if (ack[i]) begin
               granted[i] = 1'b0;
               req[i] = m[i] && pct(pk);
               if (req[i]) rnd_fields(i);
            end else if (gnt[i]) begin
               if (!granted[i]) begin
                  granted[i] = 1'b1;
                  rnd_fields(i);
                  if (pct(pd)) req[i] = 1'b0;
               end
            end else if (!granted[i]) begin
               if (req[i]) begin
                  if (pct(pw)) req[i] = 1'b0;
               end else if (m[i] && pct(pr)) begin
                  req[i] = 1'b1;
                  rnd_fields(i);
               end
            end
         end
      endtask

      task automatic run(input int n, input int pr, input int pk,
                         input int pw, input int pd, input logic [2:0] m);
         repeat (n) begin
            @(negedge clk);
            step(pr, pk, pw, pd, m);
         end
      endtask

      task automatic xfer(input int i, input bit w, input logic [11:0] a,
                          input logic [7:0] d);
         bit got;
         got = 1'b0;
         req[i] = 1'b1;
         we[i]  = w;
         addr_in[12*i +: 12] = a;
         wdata_in[8*i +: 8]  = d;
         for (int c = 0; c < 40 && !got; c++) begin
            @(negedge clk);
            if (ack[i]) begin
               got    = 1'b1;
               req[i] = 1'b0;
            end
         end
         chk($sformatf("g%0d xfer ack seen", g), 32'(got), 32'd1);
      endtask

      initial begin : stim
         rst_n    = 1'b0;
         req      = '0;
         we       = '0;
         addr_in  = '0;
         wdata_in = '0;
         granted  = '0;
         repeat (3) @(negedge clk);
         chk($sformatf("g%0d rst gnt", g), 32'(gnt), 32'd0);
         chk($sformatf("g%0d rst ack", g), 32'(ack), 32'd0);
         chk($sformatf("g%0d rst rdata", g), 32'(rdata), 32'd0);
         chk($sformatf("g%0d rst busy", g), 32'(busy), 32'd0);
         chk($sformatf("g%0d rst ram_addr", g), 32'(ram_addr), 32'd0);
         chk($sformatf("g%0d rst ram_wdata", g), 32'(ram_wdata), 32'd0);
         chk($sformatf("g%0d rst ram_wena", g), 32'(ram_wena), 32'd0);
         rst_n = 1'b1;

         @(negedge clk);
         req = 3'b010;
         we  = 3'b010;
         addr_in[23:12]  = 12'h7FF;
         wdata_in[15:8]  = 8'h5A;
         @(negedge clk);
         chk($sformatf("g%0d wena before reset", g), 32'(ram_wena), 32'd1);
         #2 rst_n = 1'b0;
         #1;
         chk($sformatf("g%0d async wena", g), 32'(ram_wena), 32'd0);
         chk($sformatf("g%0d async gnt", g), 32'(gnt), 32'd0);
         chk($sformatf("g%0d async busy", g), 32'(busy), 32'd0);
         req = 3'b000;
         we  = 3'b000;
         @(negedge clk);
         rst_n = 1'b1;

         for (int a = 0; a < 16; a++) xfer(a % 3, 1'b1, 12'(a), 8'($urandom));
         xfer(2, 1'b1, 12'hFFF, 8'h3C);
         xfer(1, 1'b1, 12'h123, 8'hA5);
         xfer(1, 1'b0, 12'h123, 8'h00);
         chk($sformatf("g%0d read 0x123", g), 32'(rdata), 32'hA5);
         xfer(2, 1'b0, 12'hFFF, 8'h00);
         chk($sformatf("g%0d read 0xFFF", g), 32'(rdata), 32'h3C);

         @(negedge clk);
         rst_n = 1'b0;
         repeat (2) @(negedge clk);
         granted = '0;
         rst_n   = 1'b1;
         req     = 3'b111;
         we      = 3'b000;
         addr_in = {12'd2, 12'd1, 12'd0};
         @(negedge clk);
         chk($sformatf("g%0d first grant", g), 32'(gnt), 32'b001);

         run(40, 100, 100, 0, 0, 3'b111);
         run(20, 100, 100, 0, 0, 3'b110);
         run(600, 30, 25, 10, 20, 3'b111);
         run(30, 0, 0, 100, 0, 3'b000);
         chk($sformatf("g%0d drained", g), 32'(q.size()), 32'd0);
         done = 1'b1;
      end
   end

   initial begin : top
      bit all_done;
      all_done = 1'b0;
      for (int c = 0; c < 5000 && !all_done; c++) begin
         @(negedge clk);
         all_done = gi[0].done && gi[1].done;
      end
      chk("run completed", 32'(all_done), 32'd1);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/dpram_port_arbiter.md
Name: dpram_port_arbiter

Overview:
- Three-way arbiter that shares one port of the 4096 x 8 DualPortRam between requesters: 0 = video fetch, 1 = CPU, 2 = blitter/DMA.
- Sequences each access as a single RAM transaction: grant, address/data drive, optional wait states, read capture, ack.
- Sits between the requesters and the RAM port. At top level, ram_wdata drives the RAM's inout data bus only while ram_wena=1; ram_rdata reads that bus.

Parameters:
- WAIT_CYCLES, 0, extra RAM access cycles inserted per transaction (0..7).
- HIPRI0, 1, when 1 requester 0 beats round-robin whenever its req is high at arbitration.

Ports:
- clk  in  1  single system clock; all state changes on rising edge.
- reset_n  in  1  asynchronous active-low reset.
- req  in  3  per-requester access request (level).
- we  in  3  per-requester write enable; 1 = write, 0 = read.
- addr_in  in  36  requester i address at bits [12i+11:12i].
- wdata_in  in  24  requester i write data at bits [8i+7:8i].
- gnt  out  3  one-hot; high for the whole ACCESS phase of the granted requester.
- ack  out  3  one-hot, one-cycle pulse at transaction completion.
- rdata  out  8  read data, valid in the ack cycle; holds until next read completes.
- busy  out  1  high in ACCESS and DONE.
- ram_addr  out  12  RAM port address.
- ram_wdata  out  8  RAM port write data.
- ram_wena  out  1  RAM port write enable.
- ram_rdata  in  8  RAM port read data (combinational from RAM).

Behaviour:
- Reset (async, any state): state=IDLE, gnt=0, ack=0, rdata=0, busy=0, ram_addr=0, ram_wdata=0, ram_wena=0, rr_ptr=2 (requester 0 first). ram_wena drops immediately on reset assertion; an interrupted write is not retried and gets no ack.
- FSM states: IDLE, ACCESS, DONE.
- IDLE:
  - On each edge with req!=0, select the winner.
  - If HIPRI0=1 and req[0]=1, the winner is 0.
  - Otherwise the winner is the first set bit searching rr_ptr+1, rr_ptr+2, rr_ptr (mod 3).
  - Latch the winner's we, addr, wdata into ram_wena/ram_addr/ram_wdata.
  - Set gnt[winner], rr_ptr=winner, wait counter=WAIT_CYCLES, go to ACCESS.
  - With req=0, stay in IDLE with all outputs idle.
- ACCESS: lasts exactly WAIT_CYCLES+1 cycles.
  - ram_wena is high only in the first ACCESS cycle, and only for a write.
  - ram_addr and ram_wdata are held for the entire phase.
  - The counter decrements each cycle. On the edge where it is 0, capture ram_rdata into rdata (reads only; writes leave rdata unchanged), clear gnt, and go to DONE.
- DONE: ack[rr_ptr]=1 for one cycle, then go to IDLE. No arbitration in DONE.
- Latency: request sampled at edge N gives gnt/ACCESS from cycle N+1 and ack in cycle N+2+WAIT_CYCLES. Throughput is one access per 3+WAIT_CYCLES cycles.
- Requests are level-sensitive:
  - A requester keeps req high until it sees ack, and must drop req in the ack cycle to avoid a second access.
  - If req is still high on the edge after ack, that is a new request.
  - Dropping req before grant withdraws it.
  - Dropping req after grant does not abort; ack still pulses.
- Requester inputs are sampled only at grant. Changes after grant are ignored.
- Simultaneous requests: exactly one gnt bit is ever set, and ack is always one-hot or zero.
- Round-robin guarantees every requester is served within 3 transactions when HIPRI0=0. With HIPRI0=1, requesters 1 and 2 may starve under continuous req[0]; this is accepted because the video path has strict priority.
- busy = (state != IDLE).

Test Plan:
- Reset values: assert reset_n=0 mid-write (ram_wena=1) -> ram_wena, gnt, busy go 0 without a clock edge; after release, the first grant with req=3'b111, HIPRI0=0 goes to requester 0.
- Write then read, WAIT_CYCLES=0:
  - Requester 1 writes 0xA5 to 0x123: ram_wena is high exactly 1 cycle and ack[1] arrives 2 cycles after the grant edge.
  - Requester 1 then reads 0x123: rdata=0xA5 in the ack cycle.
- Round-robin: HIPRI0=0, req=3'b111 held, each requester re-requests after its ack -> grant order 0,1,2,0,1,2; each access is 3 cycles apart.
- Priority: HIPRI0=1, req[0] held continuously with req[2] high -> requester 0 is granted every transaction. Dropping req[0] -> requester 2 is granted next.
- Wait states: WAIT_CYCLES=3, requester 2 reads 0xFFF holding 0x3C -> gnt[2] high 4 cycles, ack[2] at N+5, rdata=0x3C.
- Withdrawal: req[1] pulsed for 0 edges in IDLE while busy, then dropped -> no gnt[1] or ack[1]. req[2] dropped one cycle after gnt[2] -> ack[2] still pulses once.
